// File: rtl/ccff_bitstream_loader_pkg.sv
// Shared types and width helpers for the configuration-chain bitstream loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } ccff_ld_state_t;

    // Bit counter must be able to hold CHAIN_LEN itself, not just CHAIN_LEN-1.
    function automatic int cnt_width(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

    function automatic int idx_width(input int word_w);
        return (word_w > 1) ? $clog2(word_w) : 1;
    endfunction

endpackage

// File: rtl/ccff_bitstream_loader_if.sv
// Valid/ready bitstream word stream feeding the configuration-chain loader.
interface ccff_bitstream_loader_if #(
    parameter int WORD_W = 8
) ();
    logic [WORD_W-1:0] bs_data;
    logic              bs_valid;
    logic              bs_ready;

    modport master (output bs_data, output bs_valid, input bs_ready);
    modport slave  (input bs_data, input bs_valid, output bs_ready);
endinterface

// File: rtl/ccff_bitstream_loader_serializer.sv
// Holding register for one bitstream word, presented MSB-first one bit per cycle.
module ccff_word_serializer
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WORD_W-1:0] load_word,
    input  logic              advance,
    input  logic              flush,
    output logic              cur_bit,
    output logic              last_bit,
    output logic              empty
);
    localparam int IDX_W = idx_width(WORD_W);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WORD_W - 1);

    logic [WORD_W-1:0] word_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic              full_reg;
    logic [WORD_W-1:0] sel_vec;

    // Flush beats load beats advance; a load on the last bit replaces the word with no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_reg <= '0;
            idx_reg  <= '0;
            full_reg <= 1'b0;
        end else if (flush) begin
            full_reg <= 1'b0;
        end else if (load) begin
            word_reg <= load_word;
            idx_reg  <= IDX_MSB;
            full_reg <= 1'b1;
        end else if (advance && full_reg) begin
            if (idx_reg == '0) begin
                full_reg <= 1'b0;
            end else begin
                idx_reg <= idx_reg - IDX_W'(1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WORD_W; gi++) begin : g_sel
            assign sel_vec[gi] = word_reg[gi] && (idx_reg == IDX_W'(gi));
        end
    endgenerate

    assign cur_bit  = full_reg && (|sel_vec);
    assign last_bit = full_reg && (idx_reg == '0);
    assign empty    = !full_reg;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serializes a bitstream word stream onto ccff_head with a registered shift enable, stopping after CHAIN_LEN bits.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int CHAIN_LEN = 1024,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = cnt_width(CHAIN_LEN)
) (
    input  logic                    prog_clk,
    input  logic                    pReset,
    input  logic                    start,
    ccff_bitstream_loader_if.slave  bs,
    output logic                    ccff_head,
    output logic                    shift_en,
    output logic                    busy,
    output logic                    done,
    output logic                    overrun_err,
    output logic [CNT_W-1:0]        bits_loaded
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

    ccff_ld_state_t   state_reg, state_next;
    logic [CNT_W-1:0] bits_reg, bits_next;
    logic             head_reg, head_next;
    logic             sen_reg, sen_next;
    logic             done_reg, done_next;
    logic             ovr_reg, ovr_next;
    logic             ready;
    logic             ser_load, ser_advance, ser_flush;
    logic             cur_bit, last_bit, ser_empty;

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_serializer (
        .clk       (prog_clk),
        .rst       (pReset),
        .load      (ser_load),
        .load_word (bs.bs_data),
        .advance   (ser_advance),
        .flush     (ser_flush),
        .cur_bit   (cur_bit),
        .last_bit  (last_bit),
        .empty     (ser_empty)
    );

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state_reg <= ST_IDLE;
            bits_reg  <= '0;
            head_reg  <= 1'b0;
            sen_reg   <= 1'b0;
            done_reg  <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            bits_reg  <= bits_next;
            head_reg  <= head_next;
            sen_reg   <= sen_next;
            done_reg  <= done_next;
            ovr_reg   <= ovr_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        bits_next   = bits_reg;
        head_next   = 1'b0;
        sen_next    = 1'b0;
        done_next   = 1'b0;
        ovr_next    = ovr_reg;
        ready       = 1'b0;
        ser_load    = 1'b0;
        ser_advance = 1'b0;
        ser_flush   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LOAD;
                    bits_next  = '0;
                    ovr_next   = 1'b0;
                    ser_flush  = 1'b1;
                end
            end
            ST_LOAD: begin
                // Refill early on the last bit only if another bit is still owed to the chain.
                ready    = ser_empty || (last_bit && (bits_reg < LAST_CNT));
                ser_load = ready && bs.bs_valid;
                if (!ser_empty) begin
                    head_next   = cur_bit;
                    sen_next    = 1'b1;
                    bits_next   = bits_reg + CNT_W'(1);
                    ser_advance = 1'b1;
                    if (bits_reg == LAST_CNT) begin
                        state_next = ST_DONE;
                        ser_flush  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                // done lags state by one cycle so it rises after the final shift_en=1 cycle.
                done_next = 1'b1;
                if (bs.bs_valid) begin
                    ovr_next = 1'b1;
                end
                if (start) begin
                    state_next = ST_LOAD;
                    bits_next  = '0;
                    ovr_next   = 1'b0;
                    done_next  = 1'b0;
                    ser_flush  = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign bs.bs_ready  = ready;
    assign ccff_head    = head_reg;
    assign shift_en     = sen_reg;
    assign busy         = (state_reg == ST_LOAD);
    assign done         = done_reg;
    assign overrun_err  = ovr_reg;
    assign bits_loaded  = bits_reg;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench: 20-bit chain (partial final word) and 16-bit chain (exact fit), 8-bit words.
module tb_ccff_bitstream_loader;
    logic clk;
    logic rst;
    logic start_a, start_b;
    logic head_a, sen_a, busy_a, done_a, ovr_a;
    logic head_b, sen_b, busy_b, done_b, ovr_b;
    logic [4:0] bits_a, bits_b;

    int n_checks = 0;
    int n_err    = 0;
    int mcyc     = 0;

    ccff_bitstream_loader_if #(.WORD_W(8)) bs_a ();
    ccff_bitstream_loader_if #(.WORD_W(8)) bs_b ();

    ccff_bitstream_loader #(.CHAIN_LEN(20), .WORD_W(8)) dut_a (
        .prog_clk(clk), .pReset(rst), .start(start_a), .bs(bs_a),
        .ccff_head(head_a), .shift_en(sen_a), .busy(busy_a), .done(done_a),
        .overrun_err(ovr_a), .bits_loaded(bits_a)
    );

    ccff_bitstream_loader #(.CHAIN_LEN(16), .WORD_W(8)) dut_b (
        .prog_clk(clk), .pReset(rst), .start(start_b), .bs(bs_b),
        .ccff_head(head_b), .shift_en(sen_b), .busy(busy_b), .done(done_b),
        .overrun_err(ovr_b), .bits_loaded(bits_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  w0;
        logic [7:0]  w1;
        logic [7:0]  w2;
        int          gap;
        logic [19:0] exp_bits;
        int          exp_stalls;
    } vec_t;

    vec_t vecs[5];

    // Monitor state for DUT A
    bit          mon_en = 0;
    logic [31:0] cap_bits;
    int          cap_n, stall_n, cnt_bad, last_sen, done_rise;

    always @(negedge clk) begin
        mcyc++;
        if (mon_en) begin
            if (sen_a) begin
                cap_bits = {cap_bits[30:0], head_a};
                cap_n++;
                last_sen = mcyc;
                if (int'(bits_a) != cap_n) cnt_bad++;
            end else if (cap_n > 0 && cap_n < 20) begin
                stall_n++;
                if (int'(bits_a) != cap_n) cnt_bad++;
            end
            if (done_a && done_rise < 0) done_rise = mcyc;
        end
    end

    // Monitor state for DUT B
    bit          mon_b_en = 0;
    logic [31:0] capb_bits;
    int          capb_n, acc_b, ready_late;

    always @(negedge clk) begin
        if (mon_b_en) begin
            if (sen_b) begin
                capb_bits = {capb_bits[30:0], head_b};
                capb_n++;
            end
            if (acc_b >= 2 && bs_b.bs_ready) ready_late++;
            if (bs_b.bs_valid && bs_b.bs_ready) acc_b++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offers a word and returns #1 after the accepting edge.
    task automatic drive_word_a(input logic [7:0] w, output bit ok);
        ok = 0;
        bs_a.bs_data  = w;
        bs_a.bs_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bs_a.bs_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
                break;
            end
        end
        bs_a.bs_valid = 1'b0;
        $display("A word 0x%02h offered, accepted=%0d at cycle %0d", w, ok, mcyc);
    endtask

    task automatic drive_word_b(input logic [7:0] w, output bit ok);
        ok = 0;
        bs_b.bs_data  = w;
        bs_b.bs_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bs_b.bs_ready) begin
                @(posedge clk);
                #1;
                ok = 1;
                break;
            end
        end
        bs_b.bs_valid = 1'b0;
        $display("B word 0x%02h offered, accepted=%0d at cycle %0d", w, ok, mcyc);
    endtask

    task automatic run_scenario(input int k);
        bit ok;
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        check("busy_after_start", busy_a, 1);
        check("done_clear_on_start", done_a, 0);
        check("bits_clear_on_start", bits_a, 0);
        cap_bits = '0; cap_n = 0; stall_n = 0; cnt_bad = 0; last_sen = 0; done_rise = -1;
        mon_en = 1;
        drive_word_a(vecs[k].w0, ok);
        check("accept_w0", ok, 1);
        if (vecs[k].gap > 0) begin
            repeat (vecs[k].gap) @(posedge clk);
            #1;
        end
        drive_word_a(vecs[k].w1, ok);
        check("accept_w1", ok, 1);
        drive_word_a(vecs[k].w2, ok);
        check("accept_w2", ok, 1);
        for (int i = 0; i < 60; i++) begin
            if (done_a) break;
            @(negedge clk);
        end
        check("done_reached", done_a, 1);
        repeat (3) @(negedge clk);
        mon_en = 0;
        check("shift_count", cap_n, 20);
        check("bit_sequence", cap_bits[19:0], vecs[k].exp_bits);
        check("stall_cycles", stall_n, vecs[k].exp_stalls);
        check("bits_track", cnt_bad, 0);
        check("done_latency", done_rise - last_sen, 1);
        check("bits_final", bits_a, 20);
        check("busy_final", busy_a, 0);
        check("shift_en_final", sen_a, 0);
        check("no_overrun", ovr_a, 0);
        $display("A scenario %0d: bits=0x%05h shifts=%0d stalls=%0d", k, cap_bits[19:0], cap_n, stall_n);
    endtask

    initial begin
        bit ok;
        vecs[0] = '{8'hA5, 8'h3C, 8'hF0, 0,  20'hA53CF, 0};
        vecs[1] = '{8'hFF, 8'h00, 8'h81, 0,  20'hFF008, 0};
        vecs[2] = '{8'hA5, 8'h3C, 8'hF0, 10, 20'hA53CF, 3};
        vecs[3] = '{8'hA5, 8'h3C, 8'hF0, 9,  20'hA53CF, 2};
        vecs[4] = '{8'hA5, 8'h3C, 8'hF0, 1,  20'hA53CF, 0};

        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        bs_a.bs_valid = 1'b0; bs_a.bs_data = '0;
        bs_b.bs_valid = 1'b0; bs_b.bs_data = '0;
        repeat (3) @(negedge clk);
        check("rst_head", head_a, 0);
        check("rst_shift_en", sen_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_overrun", ovr_a, 0);
        check("rst_bits", bits_a, 0);
        check("rst_ready", bs_a.bs_ready, 0);
        check("rst_b_done", done_b, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // IDLE ignores the stream
        bs_a.bs_valid = 1'b1;
        bs_a.bs_data  = 8'h55;
        repeat (2) @(negedge clk);
        check("idle_ready", bs_a.bs_ready, 0);
        check("idle_shift_en", sen_a, 0);
        check("idle_overrun", ovr_a, 0);
        bs_a.bs_valid = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 5; k++) begin
            run_scenario(k);
        end

        // Overrun after DONE
        bs_a.bs_data  = 8'hFF;
        bs_a.bs_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("overrun_ready", bs_a.bs_ready, 0);
        end
        check("overrun_set", ovr_a, 1);
        bs_a.bs_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("overrun_sticky", ovr_a, 1);
        check("overrun_done_held", done_a, 1);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        check("overrun_cleared", ovr_a, 0);
        check("restart_busy", busy_a, 1);
        $display("A overrun sequence complete at cycle %0d", mcyc);

        // Reset mid-load after 10 bits
        drive_word_a(8'hA5, ok);
        check("rst_mid_accept0", ok, 1);
        drive_word_a(8'h3C, ok);
        check("rst_mid_accept1", ok, 1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bits_a == 5'd10) break;
        end
        check("rst_mid_bits10", bits_a, 10);
        rst = 1'b1;
        #1;
        check("rst_mid_head", head_a, 0);
        check("rst_mid_shift_en", sen_a, 0);
        check("rst_mid_busy", busy_a, 0);
        check("rst_mid_done", done_a, 0);
        check("rst_mid_bits", bits_a, 0);
        check("rst_mid_ready", bs_a.bs_ready, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        $display("A reset mid-load at cycle %0d", mcyc);
        run_scenario(0);

        // Exact fit with an ignored start pulse
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        capb_bits = '0; capb_n = 0; acc_b = 0; ready_late = 0;
        mon_b_en = 1;
        drive_word_b(8'h12, ok);
        check("b_accept0", ok, 1);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        check("b_start_ignored_busy", busy_b, 1);
        check("b_start_ignored_bits", bits_b, 1);
        drive_word_b(8'h34, ok);
        check("b_accept1", ok, 1);
        bs_b.bs_data  = 8'h56;
        bs_b.bs_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (done_b) break;
            @(negedge clk);
        end
        check("b_done", done_b, 1);
        repeat (3) @(negedge clk);
        mon_b_en = 0;
        bs_b.bs_valid = 1'b0;
        check("b_shift_count", capb_n, 16);
        check("b_bit_sequence", capb_bits[15:0], 16'h1234);
        check("b_accepts", acc_b, 2);
        check("b_ready_after_last", ready_late, 0);
        check("b_bits_final", bits_b, 16);
        check("b_overrun", ovr_b, 1);
        $display("B exact fit: bits=0x%04h shifts=%0d accepts=%0d", capb_bits[15:0], capb_n, acc_b);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
